// File: rtl/puf_tx_pkg.sv
// puf_tx_pkg: shared state encoding and frame constants for the PUF UART scheduler
package puf_tx_pkg;
  typedef enum logic [2:0] {IDLE, SETTLE, SEND, WAIT_DONE, FINISH} state_t;
  localparam int FRAME_LEN = 7;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
endpackage

// File: rtl/puf_rr_arb2.sv
// puf_rr_arb2: two-way round-robin arbiter producing a one-hot grant
module puf_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);
  always_comb begin
    grant[0] = req[0] & (~req[1] | last);
    grant[1] = req[1] & (~req[0] | ~last);
  end
endmodule

// File: rtl/puf_tx_scheduler.sv
// puf_tx_scheduler: frames latched PUF words as SYNC/ID/data/XOR-checksum bytes for a UART
module puf_tx_scheduler import puf_tx_pkg::*; #(
  parameter logic [7:0] SYNC_BYTE  = SYNC_DEFAULT,
  parameter int         GAP_CYCLES = 3,
  parameter int         TIMEOUT    = 16384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [31:0] req_data0,
  input  logic [31:0] req_data1,
  output logic [1:0]  ack,
  output logic        err,
  output logic        busy,
  output logic        tx_DV,
  output logic [7:0]  tx_Byte,
  input  logic        tx_Done
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 2);
  state_t state, state_nx;
  logic [1:0] grant;
  logic gnt, last, timeout;
  logic [31:0] data;
  logic [2:0] idx;
  logic [7:0] csum, cur_byte;
  logic [GW-1:0] gap_cnt;
  logic [TW-1:0] to_cnt;
  puf_rr_arb2 u_arb (.req(req), .last(last), .grant(grant));
  always_comb begin
    cur_byte = idx == 3'd0 ? SYNC_BYTE :
               idx == 3'd1 ? {7'b0, gnt} :
               idx == 3'd2 ? data[31:24] :
               idx == 3'd3 ? data[23:16] :
               idx == 3'd4 ? data[15:8] :
               idx == 3'd5 ? data[7:0] : csum;
    timeout = to_cnt >= TW'(TIMEOUT - 1);
    state_nx = state;
    case (state)
      IDLE:      state_nx = |req ? SETTLE : IDLE;
      SETTLE:    state_nx = (gap_cnt == GW'(GAP_CYCLES) && !tx_Done) ? SEND : SETTLE;
      SEND:      state_nx = WAIT_DONE;
      WAIT_DONE: state_nx = tx_Done ? (idx == 3'(FRAME_LEN - 1) ? FINISH : SETTLE) :
                            timeout ? FINISH : WAIT_DONE;
      FINISH:    state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
    tx_DV = state == SEND;
    busy = state != IDLE;
    ack = state == FINISH ? (gnt ? 2'b10 : 2'b01) : 2'b00;
    err = state == WAIT_DONE && !tx_Done && timeout;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt <= 1'b0;
      last <= 1'b1;
      data <= '0;
      idx <= '0;
      csum <= '0;
      gap_cnt <= '0;
      to_cnt <= '0;
      tx_Byte <= '0;
    end else begin
      if (state == IDLE && |req) begin
        gnt <= grant[1];
        last <= grant[1];
        data <= grant[1] ? req_data1 : req_data0;
        idx <= '0;
        csum <= '0;
        gap_cnt <= '0;
      end
      if (state == SETTLE && gap_cnt != GW'(GAP_CYCLES)) gap_cnt <= gap_cnt + 1'b1;
      if (state == SETTLE && state_nx == SEND) tx_Byte <= cur_byte;
      // checksum covers ID and data bytes only
      if (state == SEND) begin
        to_cnt <= '0;
        if (idx != 3'd0 && idx != 3'(FRAME_LEN - 1)) csum <= csum ^ tx_Byte;
      end
      if (state == WAIT_DONE) begin
        if (tx_Done) begin
          idx <= idx + 3'd1;
          gap_cnt <= '0;
        end else if (to_cnt != {TW{1'b1}}) to_cnt <= to_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_puf_tx_scheduler.sv
// tb_puf_tx_scheduler: scoreboard bench with a UART done-pulse model
module tb_puf_tx_scheduler;
  logic clk = 1'b0, rst, tx_Done, err, busy, tx_DV;
  logic [1:0] req, ack;
  logic [31:0] d0, d1;
  logic [7:0] tx_Byte;
  int checks = 0, fails = 0, cyc = 0, last_dv = -1, exp_err = 0;
  int n_dv = 0, done_limit = 1000000;
  logic [7:0] last_byte = 8'h00;
  logic prev_ack = 1'b0;
  logic [7:0] exp_b[$];
  logic [1:0] exp_a[$];

  puf_tx_scheduler dut (.clk(clk), .rst(rst), .req(req), .req_data0(d0), .req_data1(d1),
    .ack(ack), .err(err), .busy(busy), .tx_DV(tx_DV), .tx_Byte(tx_Byte), .tx_Done(tx_Done));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bad(input string name, input logic [31:0] act);
    checks++;
    fails++;
    $display("FAIL %s: got %0h expected none", name, act);
  endtask

  task automatic push_frame(input logic id, input logic [31:0] w);
    logic [7:0] c;
    c = {7'b0, id} ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    exp_b.push_back(8'hA5);
    exp_b.push_back({7'b0, id});
    exp_b.push_back(w[31:24]);
    exp_b.push_back(w[23:16]);
    exp_b.push_back(w[15:8]);
    exp_b.push_back(w[7:0]);
    exp_b.push_back(c);
  endtask

  task automatic wait_ack(input int bound);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack == 2'b00 && n < bound);
    if (ack == 2'b00) bad("ack_timeout", n);
  endtask

  task automatic wait_dv(input int cnt);
    int k, n;
    k = 0;
    n = 0;
    while (k < cnt && n < 1000) begin
      @(negedge clk);
      n++;
      if (tx_DV) k++;
    end
    chk("dv_reached", k, cnt);
  endtask

  // UART model: done pulse a few cycles after each accepted byte
  initial begin
    tx_Done = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_DV) begin
        n_dv++;
        if (n_dv <= done_limit) begin
          repeat (5) @(negedge clk);
          tx_Done = 1'b1;
          @(negedge clk);
          tx_Done = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (tx_DV) begin
        if (last_dv > 0 && cyc - last_dv < 5) bad("dv_gap", cyc - last_dv);
        last_dv = cyc;
        last_byte = tx_Byte;
        if (exp_b.size() == 0) bad("unexpected_dv", tx_Byte);
        else chk("tx_byte", tx_Byte, exp_b.pop_front());
      end
      if (tx_Done && busy) chk("byte_stable", tx_Byte, last_byte);
      if (ack != 2'b00) begin
        chk("ack_one_cycle", prev_ack, 1'b0);
        if (exp_a.size() == 0) bad("unexpected_ack", ack);
        else chk("ack", ack, exp_a.pop_front());
      end
      prev_ack = |ack;
      if (err) begin
        if (exp_err == 0) bad("unexpected_err", err);
        else begin
          exp_err--;
          chk("err_latency", cyc - last_dv, 16384);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    req = 2'b00;
    d0 = '0;
    d1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx_dv", tx_DV, 0);
    chk("rst_tx_byte", tx_Byte, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    @(negedge clk);
    // single requester, hand-computed frame
    d0 = 32'h12345678;
    exp_b.push_back(8'hA5); exp_b.push_back(8'h00); exp_b.push_back(8'h12);
    exp_b.push_back(8'h34); exp_b.push_back(8'h56); exp_b.push_back(8'h78);
    exp_b.push_back(8'h08);
    exp_a.push_back(2'b01);
    req = 2'b01;
    wait_ack(2000);
    req = 2'b00;
    repeat (5) @(negedge clk);
    // both requesting after reset: 0,1,0
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    d0 = 32'hAABBCCDD;
    d1 = 32'h11223344;
    push_frame(1'b0, d0);
    push_frame(1'b1, d1);
    push_frame(1'b0, d0);
    exp_a.push_back(2'b01);
    exp_a.push_back(2'b10);
    exp_a.push_back(2'b01);
    req = 2'b11;
    repeat (3) wait_ack(2000);
    req = 2'b00;
    repeat (5) @(negedge clk);
    // UART stalls on the third byte
    d0 = 32'hDEADBEEF;
    done_limit = n_dv + 2;
    exp_b.push_back(8'hA5); exp_b.push_back(8'h00); exp_b.push_back(8'hDE);
    exp_a.push_back(2'b01);
    exp_err = 1;
    req = 2'b01;
    wait_ack(20000);
    req = 2'b00;
    done_limit = 1000000;
    repeat (20) @(negedge clk);
    chk("err_seen", exp_err, 0);
    // reset during the fourth byte
    d0 = 32'h0BADF00D;
    exp_b.push_back(8'hA5); exp_b.push_back(8'h00); exp_b.push_back(8'h0B);
    exp_b.push_back(8'hAD);
    req = 2'b01;
    wait_dv(4);
    #2 rst = 1'b1;
    #1;
    chk("midrst_tx_dv", tx_DV, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ack", ack, 0);
    chk("midrst_err", err, 0);
    req = 2'b00;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    d0 = 32'h13579BDF;
    push_frame(1'b0, d0);
    exp_a.push_back(2'b01);
    req = 2'b01;
    wait_ack(2000);
    req = 2'b00;
    repeat (5) @(negedge clk);
    // word and request change mid-frame
    d1 = 32'hCAFEF00D;
    push_frame(1'b1, d1);
    exp_a.push_back(2'b10);
    req = 2'b10;
    wait_dv(2);
    d1 = 32'h00000000;
    req = 2'b00;
    wait_ack(2000);
    repeat (20) @(negedge clk);
    chk("bytes_left", exp_b.size(), 0);
    chk("acks_left", exp_a.size(), 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule

// File: doc/puf_tx_scheduler.md
PUF_TX_SCHEDULER -- requirements
Module: puf_tx_scheduler

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5, first byte of every frame.
REQ-002 SHALL have parameter GAP_CYCLES, default 3, idle cycles before each tx_DV pulse.
REQ-003 SHALL have parameter TIMEOUT, default 16384, maximum cycles to wait for tx_Done per byte.
REQ-004 SHALL have port clk  in  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port req  in  2  per-requester frame request, level, held until its ack.
REQ-007 SHALL have port req_data0  in  32  requester 0 PUF response word.
REQ-008 SHALL have port req_data1  in  32  requester 1 PUF response word.
REQ-009 SHALL have port ack  out  2  one-cycle pulse per requester when its frame ends, completed or aborted.
REQ-010 SHALL have port err  out  1  one-cycle pulse on a timeout abort.
REQ-011 SHALL have port busy  out  1  high from grant until the ack pulse.
REQ-012 SHALL have port tx_DV  out  1  one-cycle byte-valid pulse to the UART transmitter.
REQ-013 SHALL have port tx_Byte  out  8  byte to the UART transmitter, stable from the tx_DV pulse until tx_Done.
REQ-014 SHALL have port tx_Done  in  1  UART byte-complete; low during transmission, high at stop-bit end.

Function
REQ-015 SHALL send a 7-byte frame: SYNC_BYTE, ID byte {7'b0, granted index}, data[31:24], data[23:16], data[15:8], data[7:0], checksum.
REQ-016 SHALL compute checksum as the XOR of the ID byte and the four data bytes; SYNC_BYTE is excluded.
REQ-017 SHALL sample the granted requester's 32-bit word into an internal register in the grant cycle; later req_data changes are ignored.
REQ-018 SHALL arbitrate round-robin: with a single request, grant it; with both, grant the index other than the last granted; after reset the last granted is 1, so requester 0 wins first.
REQ-019 SHALL implement states IDLE, SETTLE, SEND, WAIT_DONE, FINISH.
REQ-020 IDLE: with any req bit high, grant, latch data, clear byte index and checksum, set busy, and go to SETTLE.
REQ-021 SETTLE: count GAP_CYCLES cycles, then go to SEND only when tx_Done is low; otherwise stay in SETTLE.
REQ-022 SEND: drive tx_Byte for the current index, pulse tx_DV for exactly one cycle, clear the timeout counter, and go to WAIT_DONE.
REQ-023 WAIT_DONE: when tx_Done is high, increment the byte index; go to SETTLE if the index is below 7, else to FINISH.
REQ-024 WAIT_DONE: if TIMEOUT cycles elapse without tx_Done high, pulse err and go to FINISH (abort).
REQ-025 FINISH: pulse ack[granted] for one cycle, clear busy, and return to IDLE; the earliest next grant is the following cycle.
REQ-026 SHALL ignore req changes while busy; a grant cannot occur in the same cycle as an ack.
REQ-027 SHALL complete a frame and pulse its ack even if the granted req falls mid-frame.
REQ-028 SHALL never assert tx_DV outside SEND; the byte-to-byte DV spacing is at least GAP_CYCLES+2 cycles.
REQ-029 SHALL size the timeout counter as $clog2(TIMEOUT+1) bits, saturating rather than wrapping.

Reset
REQ-030 rst SHALL asynchronously force IDLE, with tx_DV=0, tx_Byte=0, ack=0, err=0, busy=0, byte index 0, checksum 0, and last granted 1.
REQ-031 rst mid-frame SHALL abandon the frame with no ack and no err; the first frame after reset restarts with SYNC_BYTE.

Structure
REQ-032 Package puf_tx_pkg SHALL hold the state encoding, FRAME_LEN=7, and the default SYNC_BYTE.
REQ-033 Round-robin grant logic SHALL be a sub-module, puf_rr_arb2 (inputs req, last-granted; outputs a one-hot grant).

Verification
REQ-034 req=01, data0=32'h12345678, UART model -> bytes A5,00,12,34,56,78,08; ack=01 pulse; err never set.
REQ-035 req=11 held -> frames alternate with ID 00,01,00,...; each ack pulse is one cycle.
REQ-036 tx_Done held low after the third tx_DV -> err pulse after 16384 cycles, ack pulse, no further tx_DV.
REQ-037 rst asserted during byte 4 -> tx_DV=0 and busy=0 immediately; next frame begins with A5.
REQ-038 req_data1 changed mid-frame; req dropped mid-frame -> transmitted bytes match the word sampled at grant; ack still pulses.
